// File: rtl/led_shift_pkg.sv
// ---------------------------------------------------------------------------
// led_shift_pkg
// Shared types and defaults for led_shift_driver.
//   state_t : frame sequencer states
//   count_t : 8-bit counter type (divider and bit counter)
//   *_DEF   : default parameter values for the driver
//   sat_inc : saturating increment for count_t
// ---------------------------------------------------------------------------
package led_shift_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETUP,
    HIGH,
    ADV,
    CHK,
    PAD,
    LATCH
  } state_t;

  typedef logic [7:0] count_t;

  localparam int CLK_DIV_DEF      = 4;
  localparam int LATCH_CYCLES_DEF = 2;
  localparam int CHAIN_LEN_DEF    = 28;

  function automatic count_t sat_inc(input count_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/led_shift_driver.sv
// ---------------------------------------------------------------------------
// led_shift_driver
// Pulls segment bits out of the bit-serial 7-segment decoder one at a time
// and shifts them into an external 74HC595-style chain, then latches it.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle frame request, ignored while active
//   dec_busy   in   decoder busy flag
//   led_data   in   current segment bit from the decoder
//   next_led   out  pulse to decoder: first starts a decode, later advance
//   sr_data    out  serial data to chain, stable over a whole sr_clk period
//   sr_clk     out  chain shift clock (chain samples on rising edge)
//   sr_latch   out  chain storage latch pulse
//   active     out  frame in progress
//   done       out  single-cycle pulse as the latch pulse ends
//   bit_count  out  bits shifted this frame, saturating at 255
//
// Build option
//   LED_PAD_EN : when defined, frames shorter than CHAIN_LEN are padded with
//                zero bits (no decoder advance) so stale chain bits flush out.
// ---------------------------------------------------------------------------
module led_shift_driver
  import led_shift_pkg::*;
#(
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
`ifdef LED_PAD_EN
  ,
  parameter int CHAIN_LEN    = CHAIN_LEN_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dec_busy,
  input  logic       led_data,
  output logic       next_led,
  output logic       sr_data,
  output logic       sr_clk,
  output logic       sr_latch,
  output logic       active,
  output logic       done,
  output logic [7:0] bit_count
);

  // Divider reload values: a phase of K clocks counts K-1 down to 0.
  localparam count_t DIV_RELOAD   = count_t'(CLK_DIV - 1);
  localparam count_t LATCH_RELOAD = count_t'(LATCH_CYCLES - 1);
`ifdef LED_PAD_EN
  localparam count_t CHAIN_TARGET = count_t'(CHAIN_LEN);
`endif

  state_t state_reg, state_next;
  count_t div_cnt_reg;
  count_t bit_count_reg;
  logic   sr_data_reg;
  logic   sr_clk_reg;
  logic   sr_latch_reg;
  logic   active_reg;
  logic   done_reg;
`ifdef LED_PAD_EN
  logic   pad_reg;
`endif

  logic div_done;
  logic state_change;
  assign div_done     = (div_cnt_reg == 8'd0);
  assign state_change = (state_next != state_reg);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = ARM;
      ARM:   state_next = SETUP;
      SETUP: if (div_done) state_next = HIGH;
      HIGH: begin
        if (div_done) begin
`ifdef LED_PAD_EN
          // Pad bits return to the pad decision point, never to the decoder.
          state_next = pad_reg ? PAD : ADV;
`else
          state_next = ADV;
`endif
        end
      end
      ADV:   state_next = CHK;
      CHK: begin
        if (dec_busy) begin
          state_next = SETUP;
        end else begin
`ifdef LED_PAD_EN
          state_next = (bit_count_reg < CHAIN_TARGET) ? PAD : LATCH;
`else
          state_next = LATCH;
`endif
        end
      end
`ifdef LED_PAD_EN
      PAD:   state_next = (bit_count_reg < CHAIN_TARGET) ? SETUP : LATCH;
`endif
      LATCH: if (div_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic (combinational decoder handshake)
  // -------------------------------------------------------------------------
  always_comb begin
    next_led = 1'b0;
    if ((state_reg == IDLE && start) || state_reg == ADV) begin
      next_led = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: divider, bit counter and registered chain outputs.
  // sr_clk/sr_latch are decoded from state_next so they are clean flop outputs
  // aligned with the state they belong to.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg   <= 8'd0;
      bit_count_reg <= 8'd0;
      sr_data_reg   <= 1'b0;
      sr_clk_reg    <= 1'b0;
      sr_latch_reg  <= 1'b0;
      active_reg    <= 1'b0;
      done_reg      <= 1'b0;
`ifdef LED_PAD_EN
      pad_reg       <= 1'b0;
`endif
    end else begin
      if (state_change) begin
        div_cnt_reg <= (state_next == LATCH) ? LATCH_RELOAD : DIV_RELOAD;
      end else if (!div_done) begin
        div_cnt_reg <= div_cnt_reg - 8'd1;
      end

      sr_clk_reg   <= (state_next == HIGH);
      sr_latch_reg <= (state_next == LATCH);
      done_reg     <= (state_reg == LATCH) && (state_next == IDLE);

      if (state_reg == IDLE && start) begin
        active_reg    <= 1'b1;
        bit_count_reg <= 8'd0;
      end else if (state_reg == LATCH && state_next == IDLE) begin
        active_reg    <= 1'b0;
      end

      if (state_reg == HIGH && state_next != HIGH) begin
        bit_count_reg <= sat_inc(bit_count_reg);
      end

      // led_data is captured once at SETUP entry; sr_clk is already low here.
      if (state_change && state_next == SETUP) begin
`ifdef LED_PAD_EN
        sr_data_reg <= pad_reg ? 1'b0 : led_data;
`else
        sr_data_reg <= led_data;
`endif
      end else if (state_change && state_next == LATCH) begin
        sr_data_reg <= 1'b0;
      end

`ifdef LED_PAD_EN
      if (state_reg == IDLE && start) begin
        pad_reg <= 1'b0;
      end else if (state_next == PAD) begin
        pad_reg <= 1'b1;
      end
`endif
    end
  end

  assign sr_data   = sr_data_reg;
  assign sr_clk    = sr_clk_reg;
  assign sr_latch  = sr_latch_reg;
  assign active    = active_reg;
  assign done      = done_reg;
  assign bit_count = bit_count_reg;

endmodule
